// File: rtl/alu_pkg.sv
// Shared opcode map, flag bundle and widths for the pipelined ALU.
// ALU_SHIFT_EN enables opcodes SLL/SRL/SRA. When it is not defined, those opcodes are illegal.
package alu_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_SUB  = 4'd0,
    OP_ADD  = 4'd1,
    OP_AND  = 4'd2,
    OP_MAX  = 4'd3,
    OP_SLT  = 4'd4,
    OP_SLTU = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
    logic illegal;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_RESET = '{carry: 1'b0, zero: 1'b0, overflow: 1'b0, illegal: 1'b0};

endpackage

// File: rtl/alu_pipe_param_if.sv
// Issue-side and writeback-side handshake bundle of alu_pipe_param.
// The master is the issuer/consumer and the slave is the ALU.
interface alu_pipe_param_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [3:0]         opcode;
  logic [WIDTH-1:0]   input1;
  logic [WIDTH-1:0]   input2;
  logic [SHAMT_W-1:0] shiftValue;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               carryFlag;
  logic               zeroFlag;
  logic               overFlowFlag;
  logic               illegalOp;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, opcode, input1, input2, shiftValue, in_tag, out_ready,
    input  in_ready, out_valid, result, carryFlag, zeroFlag, overFlowFlag, illegalOp, out_tag
  );

  modport slave (
    input  in_valid, opcode, input1, input2, shiftValue, in_tag, out_ready,
    output in_ready, out_valid, result, carryFlag, zeroFlag, overFlowFlag, illegalOp, out_tag
  );
endinterface

// File: rtl/alu_core_comb.sv
// Purely combinational ALU datapath: opcode and operands go in, result and flags come out.
// The shifter is only present when ALU_SHIFT_EN is defined.
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [SHAMT_W-1:0]  shamt,
  output logic [WIDTH-1:0]    result,
  output alu_flags_t          flags
);

  localparam int MSB = WIDTH - 1;

  // One extra bit captures carry-out for ADD and borrow for SUB.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

`ifndef ALU_SHIFT_EN
  logic unused_shamt;
  assign unused_shamt = ^shamt;
`endif

  always_comb begin
    result         = '0;
    flags          = FLAGS_RESET;
    case (opcode)
      OP_SUB: begin
        result         = diff[WIDTH-1:0];
        flags.carry    = diff[WIDTH];
        flags.overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_ADD: begin
        result         = sum[WIDTH-1:0];
        flags.carry    = sum[WIDTH];
        flags.overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_AND:  result = a & b;
      OP_MAX:  result = (a >= b) ? a : b;
      OP_SLT:  result = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: result = WIDTH'(a < b);
`ifdef ALU_SHIFT_EN
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = WIDTH'($signed(a) >>> shamt);
`endif
      default: flags.illegal = 1'b1;
    endcase
    flags.zero = (result == '0);
  end

endmodule

// File: rtl/alu_pipe_param.sv
// Two-stage elastic ALU pipeline: operand register, then alu_core_comb, then result/flag register.
// ALU_SHIFT_EN adds the shift opcodes and the stage-1 shift-amount register.
module alu_pipe_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_pipe_param_if.slave   bus
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic adv1;
  logic adv2;

  logic                s1_valid_q, s1_valid_d;
  logic [OPCODE_W-1:0] s1_op_q,    s1_op_d;
  logic [WIDTH-1:0]    s1_a_q,     s1_a_d;
  logic [WIDTH-1:0]    s1_b_q,     s1_b_d;
  logic [TAG_W-1:0]    s1_tag_q,   s1_tag_d;
  logic [SHAMT_W-1:0]  s1_sh;

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    result_q,    result_d;
  alu_flags_t          flags_q,     flags_d;
  logic [TAG_W-1:0]    tag_q,       tag_d;

  logic [WIDTH-1:0]    core_result;
  alu_flags_t          core_flags;

  // Stage 2 moves when it is empty or being drained; stage 1 moves when stage 2 can take its contents.
  assign adv2        = !out_valid_q || bus.out_ready;
  assign adv1        = !s1_valid_q || adv2;
  assign bus.in_ready = adv1;

`ifdef ALU_SHIFT_EN
  logic [SHAMT_W-1:0] s1_sh_q, s1_sh_d;

  always_comb begin
    s1_sh_d = s1_sh_q;
    if (adv1 && bus.in_valid) s1_sh_d = bus.shiftValue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_sh_q <= '0;
    else        s1_sh_q <= s1_sh_d;
  end

  assign s1_sh = s1_sh_q;
`else
  logic unused_shift;
  assign unused_shift = ^bus.shiftValue;
  assign s1_sh        = '0;
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    if (adv1) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_op_d  = bus.opcode;
        s1_a_d   = bus.input1;
        s1_b_d   = bus.input2;
        s1_tag_d = bus.in_tag;
      end
    end
  end

  alu_core_comb #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .opcode (s1_op_q),
    .a      (s1_a_q),
    .b      (s1_b_q),
    .shamt  (s1_sh),
    .result (core_result),
    .flags  (core_flags)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    tag_d       = tag_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = core_result;
        flags_d  = core_flags;
        tag_d    = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_tag_q    <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= FLAGS_RESET;
      tag_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_tag_q    <= s1_tag_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      tag_q       <= tag_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.result       = result_q;
  assign bus.carryFlag    = flags_q.carry;
  assign bus.zeroFlag     = flags_q.zero;
  assign bus.overFlowFlag = flags_q.overflow;
  assign bus.illegalOp    = flags_q.illegal;
  assign bus.out_tag      = tag_q;

endmodule

// File: tb/tb_alu_pipe_param.sv
// Scoreboard bench for alu_pipe_param (WIDTH=64): directed vectors with hand-computed results.
// The shift vectors follow ALU_SHIFT_EN, so the bench matches either build.
module tb_alu_pipe_param;

  localparam int W = 64;
  localparam int T = 4;

  logic clk;
  logic rst_n;

  alu_pipe_param_if #(.WIDTH(W), .TAG_W(T)) bus ();

  alu_pipe_param #(.WIDTH(W), .TAG_W(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;  // {carry, zero, overflow, illegal}
    logic [T-1:0] t;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // The monitor pops one entry each time a result is consumed.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", bus.result, e.r);
        check("flags", {60'd0, bus.carryFlag, bus.zeroFlag, bus.overFlowFlag, bus.illegalOp}, {60'd0, e.f});
        check("tag", {60'd0, bus.out_tag}, {60'd0, e.t});
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [5:0] sh, input logic [T-1:0] tag,
                       input logic [W-1:0] er, input logic [3:0] ef);
    logic rdy;
    int   n;
    exp_t e;
    bus.in_valid   = 1'b1;
    bus.opcode     = op;
    bus.input1     = a;
    bus.input2     = b;
    bus.shiftValue = sh;
    bus.in_tag     = tag;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        e.r = er; e.f = ef; e.t = tag;
        exp_q.push_back(e);
        break;
      end
      n++;
      if (n > 50) begin
        check("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MINS = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXS = {1'b0, {(W-1){1'b1}}};

  initial begin
    int n;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.opcode     = '0;
    bus.input1     = '0;
    bus.input2     = '0;
    bus.shiftValue = '0;
    bus.in_tag     = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_result", bus.result, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Latency: accepted on one edge, visible after the next.
    issue(4'd1, ONES, 64'd1, 6'd0, 4'h1, 64'd0, 4'b1100);
    @(negedge clk);
    check("latency_not_early", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    check("latency_2", {63'd0, bus.out_valid}, 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back directed vectors at full throughput.
    issue(4'd1, MAXS, 64'd1, 6'd0, 4'h2, MINS, 4'b0010);
    issue(4'd0, 64'd0, 64'd1, 6'd0, 4'h3, ONES, 4'b1000);
    issue(4'd4, ONES, 64'd1, 6'd0, 4'h4, 64'd1, 4'b0000);
    issue(4'd5, ONES, 64'd1, 6'd0, 4'h5, 64'd0, 4'b0100);
    issue(4'd3, ONES, 64'd1, 6'd0, 4'h6, ONES, 4'b0000);
    issue(4'd12, 64'd7, 64'd9, 6'd0, 4'h7, 64'd0, 4'b0101);
    issue(4'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 6'd0, 4'h8,
          64'h00F0_00F0_00F0_00F0, 4'b0000);
    issue(4'd0, 64'd5, 64'd3, 6'd0, 4'h9, 64'd2, 4'b0000);
    issue(4'd0, MINS, 64'd1, 6'd0, 4'hA, MAXS, 4'b0010);
    issue(4'd15, 64'd1, 64'd1, 6'd0, 4'hB, 64'd0, 4'b0101);
    issue(4'd3, 64'd3, 64'd3, 6'd0, 4'hC, 64'd3, 4'b0000);
`ifdef ALU_SHIFT_EN
    issue(4'd8, MINS, 64'd0, 6'd4, 4'hD, 64'hF800_0000_0000_0000, 4'b0000);
    issue(4'd6, 64'd1, 64'd0, 6'd4, 4'hE, 64'h10, 4'b0000);
    issue(4'd7, 64'h1234, 64'd0, 6'd0, 4'hF, 64'h1234, 4'b0000);
    issue(4'd7, MINS, 64'd0, 6'd4, 4'h0, 64'h0800_0000_0000_0000, 4'b0000);
`else
    issue(4'd8, MINS, 64'd0, 6'd4, 4'hD, 64'd0, 4'b0101);
    issue(4'd6, 64'd1, 64'd0, 6'd4, 4'hE, 64'd0, 4'b0101);
`endif
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: two ops held, the third must wait.
    bus.out_ready = 1'b0;
    issue(4'd1, 64'd10, 64'd1, 6'd0, 4'h1, 64'd11, 4'b0000);
    issue(4'd1, 64'd20, 64'd2, 6'd0, 4'h2, 64'd22, 4'b0000);
    bus.in_valid = 1'b1;
    bus.opcode   = 4'd1;
    bus.input1   = 64'd30;
    bus.input2   = 64'd3;
    bus.in_tag   = 4'h3;
    repeat (4) begin
      @(negedge clk);
      check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("stall_hold_tag", {60'd0, bus.out_tag}, 64'd1);
      check("stall_hold_result", bus.result, 64'd11);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    issue(4'd1, 64'd30, 64'd3, 6'd0, 4'h3, 64'd33, 4'b0000);
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset with two ops in flight.
    bus.out_ready = 1'b0;
    issue(4'd1, ONES, 64'd1, 6'd0, 4'h5, 64'd0, 4'b1100);
    issue(4'd1, 64'd1, 64'd1, 6'd0, 4'h6, 64'd2, 4'b0000);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("async_rst_result", bus.result, 64'd0);
    check("async_rst_flags", {60'd0, bus.carryFlag, bus.zeroFlag, bus.overFlowFlag, bus.illegalOp}, 64'd0);
    check("async_rst_tag", {60'd0, bus.out_tag}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_stale_after_reset", {63'd0, bus.out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    issue(4'd0, 64'd9, 64'd9, 6'd0, 4'h7, 64'd0, 4'b0100);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
